// File: rtl/uart_echo_checker.sv
`timescale 1ns/1ps
// Purpose : UART initiator that sends SEED, SEED+1, ... and checks each byte echoed back on rx.
// Latency : tx start bit one cycle after start is taken; 10*DIV cycles per frame, reply awaited for TIMEOUT*DIV cycles.
// Backpressure: none; start is ignored while busy, stray echoes outside the reply window are dropped.
module uart_echo_checker #(
  parameter int         FCLK    = 100000000,
  parameter int         BAUD    = 115200,
  parameter int         NBYTES  = 16,
  parameter logic [7:0] SEED    = 8'h00,
  parameter int         TIMEOUT = 40
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       rx,
  output logic       tx,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_cnt
);

  localparam int DIV    = FCLK / BAUD;
  localparam int HALF   = DIV / 2;
  localparam int TO_CYC = TIMEOUT * DIV;
  localparam int CW     = $clog2(DIV + 1);
  localparam int TW     = $clog2(TO_CYC + 1);

  localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  localparam logic [TW-1:0] TO_M1   = TW'(TO_CYC - 1);
  localparam logic [7:0]    LAST    = 8'(NBYTES - 1);

  // Main FSM encoding
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SEND = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_NEXT = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  // Receiver encoding
  localparam logic [1:0] R_IDLE  = 2'd0;
  localparam logic [1:0] R_START = 2'd1;
  localparam logic [1:0] R_DATA  = 2'd2;
  localparam logic [1:0] R_STOP  = 2'd3;

  // Receiver state
  logic          rx_s1, rx_s2, rx_q;
  logic          rx_fall;
  logic [1:0]    rx_st;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_sh;
  logic          rx_vld;
  logic [7:0]    rx_dat;
  logic          rx_ferr;

  // Transmitter / sequencer state
  logic [2:0]    state;
  logic [7:0]    idx;
  logic [7:0]    cur_byte;
  logic [8:0]    tx_sh;
  logic [3:0]    tx_bit;
  logic [CW-1:0] tx_cnt;
  logic          tx_run;
  logic [TW-1:0] to_cnt;

  // An echo that completes while our own stop bit is still on the line is held here
  // until the reply window opens; with a zero-delay loopback this is the normal case.
  logic          rx_pend;
  logic [7:0]    pend_dat;
  logic          pend_ferr;

  logic          got;
  logic [7:0]    got_dat;
  logic          got_bad;
  logic [7:0]    err_sat;

  assign rx_fall = rx_q & ~rx_s2;

  // Two-flop synchroniser plus one delayed copy for falling-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_q  <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      rx_q  <= rx_s2;
    end
  end

  // Receiver: half-bit start check, then centre sampling of 8 data bits and the stop bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_st   <= R_IDLE;
      rx_cnt  <= '0;
      rx_bit  <= '0;
      rx_sh   <= '0;
      rx_vld  <= 1'b0;
      rx_dat  <= '0;
      rx_ferr <= 1'b0;
    end else begin
      rx_vld <= 1'b0;
      case (rx_st)
        R_IDLE: begin
          if (rx_fall) begin
            rx_cnt <= HALF_M1;
            rx_st  <= R_START;
          end
        end
        R_START: begin
          if (rx_cnt != '0) begin
            rx_cnt <= rx_cnt - 1'b1;
          end else if (rx_s2) begin
            // line already back high at mid-start: glitch, not a frame
            rx_st <= R_IDLE;
          end else begin
            rx_cnt <= DIV_M1;
            rx_bit <= '0;
            rx_st  <= R_DATA;
          end
        end
        R_DATA: begin
          if (rx_cnt != '0) begin
            rx_cnt <= rx_cnt - 1'b1;
          end else begin
            rx_sh  <= {rx_s2, rx_sh[7:1]};
            rx_cnt <= DIV_M1;
            rx_bit <= rx_bit + 1'b1;
            if (rx_bit == 3'd7) begin
              rx_st <= R_STOP;
            end
          end
        end
        R_STOP: begin
          if (rx_cnt != '0) begin
            rx_cnt <= rx_cnt - 1'b1;
          end else begin
            rx_vld  <= 1'b1;
            rx_dat  <= rx_sh;
            rx_ferr <= ~rx_s2;
            rx_st   <= R_IDLE;
          end
        end
        default: rx_st <= R_IDLE;
      endcase
    end
  end

  // Select the echo to judge (held one first) and precompute the saturating increment
  always_comb begin
    got     = rx_pend | rx_vld;
    got_dat = rx_pend ? pend_dat : rx_dat;
    got_bad = (got_dat != cur_byte) | (rx_pend ? pend_ferr : rx_ferr);
    err_sat = (err_cnt == 8'hFF) ? 8'hFF : err_cnt + 8'd1;
  end

  // Sequencer: serialise byte i, await its echo or timeout, advance, report
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      tx        <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_cnt   <= '0;
      idx       <= '0;
      cur_byte  <= SEED;
      tx_sh     <= '1;
      tx_bit    <= '0;
      tx_cnt    <= '0;
      tx_run    <= 1'b0;
      to_cnt    <= '0;
      rx_pend   <= 1'b0;
      pend_dat  <= '0;
      pend_ferr <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_SEND;
            busy     <= 1'b1;
            err_cnt  <= '0;
            pass     <= 1'b0;
            idx      <= '0;
            cur_byte <= SEED;
            tx_run   <= 1'b0;
            rx_pend  <= 1'b0;
          end
        end
        S_SEND: begin
          if (!tx_run) begin
            tx     <= 1'b0;
            tx_sh  <= {1'b1, cur_byte};
            tx_bit <= '0;
            tx_cnt <= DIV_M1;
            tx_run <= 1'b1;
          end else if (tx_cnt != '0) begin
            tx_cnt <= tx_cnt - 1'b1;
          end else if (tx_bit == 4'd9) begin
            // stop bit finished: open the reply window
            tx_run <= 1'b0;
            to_cnt <= TO_M1;
            state  <= S_WAIT;
          end else begin
            tx     <= tx_sh[0];
            tx_sh  <= {1'b1, tx_sh[8:1]};
            tx_bit <= tx_bit + 1'b1;
            tx_cnt <= DIV_M1;
          end
          if (tx_run && (tx_bit == 4'd9) && rx_vld) begin
            rx_pend   <= 1'b1;
            pend_dat  <= rx_dat;
            pend_ferr <= rx_ferr;
          end
        end
        S_WAIT: begin
          // a reply arriving on the expiry cycle still counts as a reply
          if (got) begin
            if (got_bad) begin
              err_cnt <= err_sat;
            end
            rx_pend <= 1'b0;
            state   <= S_NEXT;
          end else if (to_cnt == '0) begin
            err_cnt <= err_sat;
            state   <= S_NEXT;
          end else begin
            to_cnt <= to_cnt - 1'b1;
          end
        end
        S_NEXT: begin
          if (idx == LAST) begin
            state <= S_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
            pass  <= (err_cnt == 8'd0);
          end else begin
            // launch the next start bit directly from here
            idx      <= idx + 8'd1;
            cur_byte <= cur_byte + 8'd1;
            state    <= S_SEND;
            tx       <= 1'b0;
            tx_sh    <= {1'b1, cur_byte + 8'd1};
            tx_bit   <= '0;
            tx_cnt   <= DIV_M1;
            tx_run   <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_echo_checker.sv
`timescale 1ns/1ps
// Directed bench for uart_echo_checker: loopback, silent line, corrupted and
// framing-error echoes, glitches, mid-run restart and reset, plus saturation.
module tb_uart_echo_checker;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start, rx, tx, busy, done, pass;
  logic [7:0] err_cnt;
  logic       start2, tx2, busy2, done2, pass2;
  logic [7:0] err2;

  logic       rx_drv;
  int         echo_mode = 0;   // 0 loopback, 1 silent, 2 xor echo, 3 stop-low echo, 4 glitch then echo
  int         xor_idx   = -1;  // byte index to corrupt in mode 2, 99 = every byte
  int         frames_seen = 0;
  int         run_base  = 0;
  logic       frame_active = 1'b0;

  logic [7:0] exp_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;

  assign rx = (echo_mode == 0) ? tx : rx_drv;

  uart_echo_checker #(
    .FCLK(1000000), .BAUD(100000), .NBYTES(16), .SEED(8'hA0), .TIMEOUT(40)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rx(rx),
    .tx(tx), .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt)
  );

  uart_echo_checker #(
    .FCLK(400000), .BAUD(100000), .NBYTES(255), .SEED(8'h00), .TIMEOUT(1)
  ) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start2), .rx(1'b1),
    .tx(tx2), .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int tz(input logic [7:0] v);
    int n = 0;
    while (n < 8 && !v[n]) n++;
    return n;
  endfunction

  // Line monitor and echo model: decodes each tx frame, scores it, optionally replies on rx
  initial begin
    logic       tx_last;
    logic [99:0] line;
    logic [7:0] b, e, r;
    logic       abort, stop_val;
    int         lowrun, bidx;
    tx_last = 1'b1;
    rx_drv  = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (rst_n && tx_last && !tx) begin
        frame_active = 1'b1;
        abort   = 1'b0;
        line    = '0;
        line[0] = tx;
        for (int k = 1; k < 100; k++) begin
          @(posedge clk); #1;
          line[k] = tx;
          if (!rst_n) abort = 1'b1;
        end
        frame_active = 1'b0;
        if (!abort) begin
          for (int j = 0; j < 8; j++) b[j] = line[10*j + 15];
          lowrun = 0;
          while (lowrun < 100 && !line[lowrun]) lowrun++;
          if (exp_q.size() == 0) begin
            check("tx_byte_unexpected", {24'h0, b}, 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check("tx_byte", {24'h0, b}, {24'h0, e});
            check("tx_low_run", lowrun, 10 * (1 + tz(e)));
            check("tx_stop_bit", {31'h0, line[95]}, 32'h1);
          end
          bidx = frames_seen - run_base;
          frames_seen++;
          if (echo_mode >= 2) begin
            r = b;
            if (echo_mode == 2 && (xor_idx == 99 || xor_idx == bidx)) r = b ^ 8'h01;
            stop_val = (echo_mode == 3) ? 1'b0 : 1'b1;
            if (echo_mode == 4) begin
              repeat (20) @(posedge clk);
              #1 rx_drv = 1'b0;
              repeat (3) @(posedge clk);
              #1 rx_drv = 1'b1;
              repeat (15) @(posedge clk);
            end
            repeat (4) @(posedge clk);
            #1 rx_drv = 1'b0;
            for (int j = 0; j < 8; j++) begin
              repeat (10) @(posedge clk);
              #1 rx_drv = r[j];
            end
            repeat (10) @(posedge clk);
            #1 rx_drv = stop_val;
            repeat (8) @(posedge clk);
            #1 rx_drv = 1'b1;
          end
        end
        tx_last = tx;
      end else begin
        tx_last = tx;
      end
    end
  end

  // Safety net against a hung run
  initial begin
    #900us;
    $display("FAIL watchdog: simulation did not finish, observed hang expected finish");
    $fatal(1, "watchdog");
  end

  task automatic start_run();
    @(negedge clk);
    for (int i = 0; i < 16; i++) exp_q.push_back(8'(8'hA0 + i));
    run_base = frames_seen;
    start = 1'b1;
    @(posedge clk); #1;
    check("busy_at_start_edge", {31'h0, busy}, 32'h1);
    check("tx_idle_at_start_edge", {31'h0, tx}, 32'h1);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    check("tx_falls_next_edge", {31'h0, tx}, 32'h0);
  endtask

  task automatic wait_done(input int budget, output int cycles);
    cycles = 0;
    while (!done && cycles < budget) begin
      @(posedge clk); #1;
      cycles++;
    end
    check("done_seen", {31'h0, done}, 32'h1);
    check("busy_low_with_done", {31'h0, busy}, 32'h0);
  endtask

  task automatic wait_frames(input int n, input int budget);
    int c = 0;
    while ((frames_seen - run_base) < n && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
    check("frames_reached", {31'h0, ((frames_seen - run_base) >= n)}, 32'h1);
  endtask

  task automatic end_of_run(input logic [7:0] exp_err, input logic exp_pass, input string tag);
    check({tag, "_err_cnt"}, {24'h0, err_cnt}, {24'h0, exp_err});
    check({tag, "_pass"}, {31'h0, pass}, {31'h0, exp_pass});
    @(posedge clk); #1;
    check({tag, "_done_one_cycle"}, {31'h0, done}, 32'h0);
    check({tag, "_pass_held"}, {31'h0, pass}, {31'h0, exp_pass});
    repeat (10) @(posedge clk); #1;
    check({tag, "_frames"}, frames_seen - run_base, 16);
    check({tag, "_queue_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    int cyc;
    rst_n  = 1'b0;
    start  = 1'b0;
    start2 = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("rst_tx", {31'h0, tx}, 32'h1);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_pass", {31'h0, pass}, 32'h0);
    check("rst_err_cnt", {24'h0, err_cnt}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);

    // Direct loopback with a second start pulse mid-run
    echo_mode = 0;
    start_run();
    wait_frames(4, 2000);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_done(3000, cyc);
    end_of_run(8'd0, 1'b1, "loopback");

    // Silent line: every byte times out
    echo_mode = 1;
    start_run();
    wait_done(9000, cyc);
    check("timeout_run_length_ok", {31'h0, (cyc >= 7900 && cyc <= 8100)}, 32'h1);
    end_of_run(8'd16, 1'b0, "timeout");

    // Echo corrupts byte 5 only
    echo_mode = 2;
    xor_idx   = 5;
    start_run();
    wait_done(6000, cyc);
    end_of_run(8'd1, 1'b0, "xor5");

    // Echo with stop bit low on every reply
    echo_mode = 3;
    start_run();
    wait_done(6000, cyc);
    end_of_run(8'd16, 1'b0, "stoplow");

    // Short glitch on rx before each correct echo
    echo_mode = 4;
    start_run();
    wait_done(7000, cyc);
    end_of_run(8'd0, 1'b1, "glitch");

    // Reset in the middle of byte 3, echo corrupting every byte
    echo_mode = 2;
    xor_idx   = 99;
    start_run();
    wait_frames(3, 2000);
    cyc = 0;
    while (!frame_active && cyc < 500) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("byte3_started", {31'h0, frame_active}, 32'h1);
    repeat (35) @(posedge clk);
    #3;
    check("err_before_reset", {24'h0, err_cnt}, 32'h3);
    rst_n = 1'b0;
    #1;
    check("midrst_tx", {31'h0, tx}, 32'h1);
    check("midrst_busy", {31'h0, busy}, 32'h0);
    check("midrst_err_cnt", {24'h0, err_cnt}, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (120) @(posedge clk); #1;
    check("post_rst_tx_idle", {31'h0, tx}, 32'h1);
    exp_q.delete();
    echo_mode = 0;
    start_run();
    wait_done(3000, cyc);
    end_of_run(8'd0, 1'b1, "after_reset");

    // Long silent run on the second instance: error count tops out at 255
    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    cyc = 0;
    while (!done2 && cyc < 20000) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("sat_done_seen", {31'h0, done2}, 32'h1);
    check("sat_err_cnt", {24'h0, err2}, 32'hFF);
    check("sat_pass", {31'h0, pass2}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
